// File: rtl/pq_systolic_path.sv
// pq_systolic_path: sorted systolic (key, data) priority-queue path.
// Define PQ_MAX_FIRST_EN for max-first (descending) ordering.
module pq_systolic_path #(
    parameter int KEY_W  = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                         system1000,
    input  logic                         system1000_rst,
    input  logic                         cmd_valid,
    input  logic [1:0]                   cmd_op,
    input  logic [KEY_W-1:0]             cmd_key,
    input  logic [DATA_W-1:0]            cmd_data,
    output logic                         cmd_ready,
    output logic                         out_valid,
    output logic [KEY_W-1:0]             out_key,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    input  logic                         err_clr,
    output logic                         ovf,
    output logic                         udf
);

    localparam int CW = $clog2(DEPTH+1);

    logic [KEY_W-1:0]  key_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [KEY_W-1:0]  nxt_key  [DEPTH];
    logic [DATA_W-1:0] nxt_data [DEPTH];
    logic [CW-1:0]     nxt_cnt;
    logic [DEPTH-1:0]  gt;
    logic              fire, do_ins, do_ext, do_rep;
    logic              out_set, ovf_set, udf_set;
    logic [KEY_W-1:0]  out_k;
    logic [DATA_W-1:0] out_d;
    int                ins_pos, rep_pos;

    assign cmd_ready = ~system1000_rst;
    assign fire      = cmd_valid && cmd_ready;
    assign do_ins    = fire && (cmd_op == 2'b01);
    assign do_ext    = fire && (cmd_op == 2'b10);
    assign do_rep    = fire && (cmd_op == 2'b11);
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));

    // True when stored key a must sit after a new key b.
    function automatic logic after_key(input logic [KEY_W-1:0] a,
                                       input logic [KEY_W-1:0] b);
`ifdef PQ_MAX_FIRST_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    // One parallel comparator per valid cell against the command key.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            gt[i] = (i < int'(count)) && after_key(key_q[i], cmd_key);
        end
    end

    // Priority select; replace ignores the departing head cell.
    always_comb begin
        ins_pos = int'(count);
        rep_pos = int'(count);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (gt[i]) ins_pos = i;
        end
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (gt[i]) rep_pos = i;
        end
    end

    // Next array contents, occupancy, output and error events.
    always_comb begin
        nxt_key  = key_q;
        nxt_data = data_q;
        nxt_cnt  = count;
        out_set  = 1'b0;
        out_k    = cmd_key;
        out_d    = cmd_data;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        unique case (1'b1)
            do_ins: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    for (int j = 1; j < DEPTH; j++) begin
                        if (j > ins_pos) begin
                            nxt_key[j]  = key_q[j-1];
                            nxt_data[j] = data_q[j-1];
                        end
                    end
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == ins_pos) begin
                            nxt_key[j]  = cmd_key;
                            nxt_data[j] = cmd_data;
                        end
                    end
                    nxt_cnt = count + CW'(1);
                end
            end
            do_ext: begin
                if (empty) begin
                    udf_set = 1'b1;
                end else begin
                    out_set = 1'b1;
                    out_k   = key_q[0];
                    out_d   = data_q[0];
                    for (int j = 0; j < DEPTH - 1; j++) begin
                        nxt_key[j]  = key_q[j+1];
                        nxt_data[j] = data_q[j+1];
                    end
                    nxt_cnt = count - CW'(1);
                end
            end
            do_rep: begin
                out_set = 1'b1;
                if (!empty) begin
                    out_k = key_q[0];
                    out_d = data_q[0];
                    for (int j = 0; j < DEPTH - 1; j++) begin
                        if (j < rep_pos - 1) begin
                            nxt_key[j]  = key_q[j+1];
                            nxt_data[j] = data_q[j+1];
                        end
                    end
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == rep_pos - 1) begin
                            nxt_key[j]  = cmd_key;
                            nxt_data[j] = cmd_data;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Array, occupancy, registered output and sticky flags.
    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                key_q[j]  <= '0;
                data_q[j] <= '0;
            end
            count     <= '0;
            out_valid <= 1'b0;
            out_key   <= '0;
            out_data  <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            key_q     <= nxt_key;
            data_q    <= nxt_data;
            count     <= nxt_cnt;
            out_valid <= out_set;
            if (out_set) begin
                out_key  <= out_k;
                out_data <= out_d;
            end
            ovf <= ovf_set | (ovf & ~err_clr);
            udf <= udf_set | (udf & ~err_clr);
        end
    end

endmodule

// File: tb/tb_pq_systolic_path.sv
// tb_pq_systolic_path: directed and random checks of pq_systolic_path
// against a queue-based reference model.
module tb_pq_systolic_path;

    localparam int KW = 32;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [KW-1:0] cmd_key = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          err_clr = 1'b0;
    logic          cmd_ready, out_valid, empty, full, ovf, udf;
    logic [KW-1:0] out_key;
    logic [DW-1:0] out_data;
    logic [4:0]    count;

    int checks = 0;
    int failures = 0;

    pq_systolic_path #(.KEY_W(KW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .cmd_valid      (cmd_valid),
        .cmd_op         (cmd_op),
        .cmd_key        (cmd_key),
        .cmd_data       (cmd_data),
        .cmd_ready      (cmd_ready),
        .out_valid      (out_valid),
        .out_key        (out_key),
        .out_data       (out_data),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .err_clr        (err_clr),
        .ovf            (ovf),
        .udf            (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [KW-1:0] k;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m_valid = 1'b0;
    logic [KW-1:0] m_key = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    function automatic bit m_after(input logic [KW-1:0] a,
                                   input logic [KW-1:0] b);
`ifdef PQ_MAX_FIRST_EN
        return a < b;
`else
        return a > b;
`endif
    endfunction

    task automatic m_insert(input logic [KW-1:0] k, input logic [DW-1:0] d);
        int idx;
        ent_t e;
        idx = mq.size();
        for (int i = mq.size() - 1; i >= 0; i--)
            if (m_after(mq[i].k, k)) idx = i;
        e.k = k;
        e.d = d;
        mq.insert(idx, e);
    endtask

    // Reference model: queue semantics evaluated at every rising edge.
    always @(posedge clk) begin
        bit ov, ud;
        if (rst) begin
            mq.delete();
            m_valid = 1'b0;
            m_key = '0;
            m_data = '0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            ov = 1'b0;
            ud = 1'b0;
            m_valid = 1'b0;
            if (cmd_valid) begin
                case (cmd_op)
                    2'b01: begin
                        if (mq.size() == DEPTH) ov = 1'b1;
                        else m_insert(cmd_key, cmd_data);
                    end
                    2'b10: begin
                        if (mq.size() == 0) ud = 1'b1;
                        else begin
                            m_valid = 1'b1;
                            m_key = mq[0].k;
                            m_data = mq[0].d;
                            void'(mq.pop_front());
                        end
                    end
                    2'b11: begin
                        m_valid = 1'b1;
                        if (mq.size() == 0) begin
                            m_key = cmd_key;
                            m_data = cmd_data;
                        end else begin
                            m_key = mq[0].k;
                            m_data = mq[0].d;
                            void'(mq.pop_front());
                            m_insert(cmd_key, cmd_data);
                        end
                    end
                    default: ;
                endcase
            end
            m_ovf = ov | (m_ovf & ~err_clr);
            m_udf = ud | (m_udf & ~err_clr);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_key", 64'(out_key), 64'(m_key));
        check("out_data", 64'(out_data), 64'(m_data));
        check("count", 64'(count), 64'(mq.size()));
        check("empty", 64'(empty), 64'(mq.size() == 0));
        check("full", 64'(full), 64'(mq.size() == DEPTH));
        check("ovf", 64'(ovf), 64'(m_ovf));
        check("udf", 64'(udf), 64'(m_udf));
        check("cmd_ready", 64'(cmd_ready), 64'(!rst));
    end

    task automatic step(input logic v, input logic [1:0] op,
                        input logic [KW-1:0] k, input logic [DW-1:0] d,
                        input logic clr);
        @(negedge clk);
        cmd_valid = v;
        cmd_op = op;
        cmd_key = k;
        cmd_data = d;
        err_clr = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic ins(input int k, input int d);
        step(1'b1, 2'b01, KW'(k), DW'(d), 1'b0);
    endtask

    task automatic ext();
        step(1'b1, 2'b10, '0, '0, 1'b0);
    endtask

    task automatic rep(input int k, input int d);
        step(1'b1, 2'b11, KW'(k), DW'(d), 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic drain();
        while (!empty) ext();
    endtask

    initial begin
        int exp_k[4];
        int exp_d[4];
        int guard;

        rst = 1'b1;
        idle();
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_out_key", 64'(out_key), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        ins(5, 'h5);
        ins(2, 'hA);
        ins(9, 'h9);
        ins(2, 'hB);
`ifdef PQ_MAX_FIRST_EN
        exp_k = '{9, 5, 2, 2};
        exp_d = '{'h9, 'h5, 'hA, 'hB};
`else
        exp_k = '{2, 2, 5, 9};
        exp_d = '{'hA, 'hB, 'h5, 'h9};
`endif
        for (int i = 0; i < 4; i++) begin
            ext();
            check("seq_valid", 64'(out_valid), 64'(1));
            check("seq_key", 64'(out_key), 64'(exp_k[i]));
            check("seq_data", 64'(out_data), 64'(exp_d[i]));
        end
        check("seq_count", 64'(count), 64'(0));
        check("seq_empty", 64'(empty), 64'(1));

        for (int i = 0; i < DEPTH; i++) ins(i, i + 'h100);
        check("fill_full", 64'(full), 64'(1));
        ins(3, 'h333);
        check("ovf_set", 64'(ovf), 64'(1));
        check("ovf_count", 64'(count), 64'(16));
        step(1'b0, 2'b00, '0, '0, 1'b1);
        check("ovf_clr", 64'(ovf), 64'(0));
        ext();
`ifdef PQ_MAX_FIRST_EN
        check("full_head", 64'(out_key), 64'(15));
`else
        check("full_head", 64'(out_key), 64'(0));
`endif
        drain();

        ext();
        check("udf_no_valid", 64'(out_valid), 64'(0));
        check("udf_set", 64'(udf), 64'(1));
        rep(7, 'h77);
        check("rep_empty_valid", 64'(out_valid), 64'(1));
        check("rep_empty_key", 64'(out_key), 64'(7));
        check("rep_empty_count", 64'(count), 64'(0));
        step(1'b0, 2'b00, '0, '0, 1'b1);

        ins(1, 'h1);
        ins(4, 'h4);
        ins(8, 'h8);
        rep(6, 'h6);
        ext();
`ifdef PQ_MAX_FIRST_EN
        check("rep_after_ext", 64'(out_key), 64'(6));
`else
        check("rep_after_ext", 64'(out_key), 64'(4));
`endif
        drain();

`ifdef PQ_MAX_FIRST_EN
        ins(3, 'h3);
        ins(10, 'h10);
        ins(7, 'h7);
        ext();
        check("max_k0", 64'(out_key), 64'(10));
        ext();
        check("max_k1", 64'(out_key), 64'(7));
        ext();
        check("max_k2", 64'(out_key), 64'(3));
`endif

        for (int i = 0; i < 5; i++) ins(i * 3, i);
        check("pre_rst_count", 64'(count), 64'(5));
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_key = 32'd42;
        @(posedge clk);
        #2;
        check("mid_rst_count", 64'(count), 64'(0));
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        ext();
        check("post_rst_udf", 64'(udf), 64'(1));

        guard = 0;
        repeat (3000) begin
            int r;
            logic [KW-1:0] k;
            r = $urandom_range(0, 99);
            k = ($urandom_range(0, 3) == 0) ? KW'($urandom) :
                KW'($urandom_range(0, 7));
            if (r == 0) begin
                @(negedge clk);
                rst = 1'b1;
                cmd_valid = 1'b1;
                cmd_op = 2'b01;
                @(posedge clk);
                #2;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                step($urandom_range(0, 9) != 0,
                     (r < 45) ? 2'b01 : (r < 80) ? 2'b10 :
                     (r < 95) ? 2'b11 : 2'b00,
                     k, DW'($urandom), $urandom_range(0, 15) == 0);
            end
            guard++;
        end
        check("random_ran", 64'(guard), 64'(3000));

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pq_systolic_path.md
# pq_systolic_path

Parametrised systolic priority-queue path: a sorted shift-register array of DEPTH (key, data) cells that accepts insert, extract-min and replace commands at one command per cycle. It generalises the fixed 64-bit-entry queue path. Key and payload widths, depth and ordering direction are configurable, and it adds a replace operation, occupancy reporting and sticky error flags. It sits between the scheduler front-end and the dispatch logic in the system1000 clock domain.

## Interface
- KEY_W, 32, key width in bits, compared unsigned
- DATA_W, 32, payload width carried with each key
- DEPTH, 16, number of queue cells, ≥2
- system1000  in  1  clock, rising edge
- system1000_rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present this cycle
- cmd_op  in  2  command: 01 insert, 10 extract, 11 replace, 00 no-op
- cmd_key  in  KEY_W  key for insert/replace
- cmd_data  in  DATA_W  payload for insert/replace
- cmd_ready  out  1  constant 1 out of reset, 0 during reset
- out_valid  out  1  extracted entry valid, one-cycle pulse
- out_key  out  KEY_W  extracted key
- out_data  out  DATA_W  extracted payload
- count  out  $clog2(DEPTH+1)  current occupancy
- empty  out  1  count==0
- full  out  1  count==DEPTH
- err_clr  in  1  clears sticky error flags
- ovf  out  1  sticky: insert attempted while full
- udf  out  1  sticky: extract attempted while empty

## Operation
- Cell 0 always holds the head: the minimum key, or the maximum with PQ_MAX_FIRST_EN. Cells 0..count-1 are valid and sorted. Cells ≥count are don't-care internally and carry no observable effect.
- Insert: every valid cell i compares cmd_key. The insertion point p is the first cell whose key orders strictly after cmd_key, or count if there is none. Cells p..count-1 shift right by one, the new entry lands in p, and count increments. Equal keys keep arrival (FIFO) order.
- Extract: the head is registered to out_key/out_data, out_valid pulses, cells shift left by one, and count decrements.
- Replace is extract-then-insert in one cycle:
  - The old head is output.
  - The new entry is placed among the remaining count-1 entries.
  - count is unchanged.
- Boundary cases:
  - Insert while full: command dropped, array unchanged, ovf set.
  - Extract while empty: no out_valid, udf set.
  - Replace while empty: out_valid with cmd_key/cmd_data passed through, queue stays empty, no flag.
  - Replace while full: legal, count stays DEPTH.
- cmd_op 00 with cmd_valid does nothing. When cmd_valid=0, cmd_op is ignored.
- err_clr clears ovf/udf. If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- Reset: count=0, empty=1, full=0, out_valid=0, out_key=0, out_data=0, ovf=0, udf=0, cmd_ready=0. Cell contents are cleared to 0. Reset mid-stream discards all entries, and any command presented that cycle is ignored.

## Timing
- One command accepted per cycle whenever cmd_ready=1. No backpressure; the handshake is cmd_valid && cmd_ready.
- Extract/replace output latency is 1 cycle: command in cycle N gives out_valid, out_key and out_data registered at edge N+1, held until the next edge. out_key/out_data keep their last value when out_valid=0.
- count, empty, full, ovf and udf update at the same edge as the array. A command in cycle N+1 sees the result of the command in cycle N (back-to-back, no bubbles).
- The insertion-point compare is a single combinational level of DEPTH parallel comparators plus a priority select. No multi-cycle paths.

## Configuration
- PQ_MAX_FIRST_EN defined: ordering is descending, so the head is the largest key, and "orders strictly after" means strictly smaller.
- PQ_MAX_FIRST_EN undefined: ordering is ascending, so the head is the smallest key (default).
- Tie handling (FIFO among equal keys) is identical in both builds.

## Test plan
- Reset, then insert keys 5, 2, 9, 2(data=0xB), then extract ×4 → out_key 2,2,5,9. The second 2 carries data 0xB. count ends 0 and empty=1.
- Fill DEPTH=16 with keys 0..15, then insert key 3 → ovf=1, count=16, array unchanged; err_clr → ovf=0.
- Extract on an empty queue → no out_valid, udf=1. Then replace key 7 on empty → out_valid with key 7 next cycle, count stays 0.
- Queue {1,4,8}, replace key 6 → out_key=1, queue becomes {4,6,8}, count=3. Back-to-back extract in the next cycle → out_key=4.
- Build with PQ_MAX_FIRST_EN, insert 3, 10, 7, extract ×3 → out_key 10, 7, 3.
- Assert system1000_rst while count=5 and an insert is presented → count=0, out_valid=0, the insert is lost. The first extract after reset sets udf.
